// File: rtl/small_multiplier_pkg.sv
// Shared constants for the serial arithmetic blocks (multiplier and divider).
// Holds the control-state encoding used by both FSMs.
package small_multiplier_pkg;

    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_CALC = 1'b1
    } state_t;

endpackage

// File: rtl/plus1.sv
// Incrementer used for the step counter; wraps silently at 2**WIDTH.
module plus1 #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] result
);

    assign result = value + WIDTH'(1);

endmodule

// File: rtl/small_multiplier.sv
// Unsigned shift-and-add multiplier: one WIDTH+1-bit add per clock, WIDTH steps per product.
// done pulses for one cycle when product updates; busy covers the CALC steps only.
module small_multiplier
    import small_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned WIDTH_LOG_MAX = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    state_t                   state_q, state_d;
    logic [WIDTH-1:0]         mc_q, mc_d;
    logic [2*WIDTH:0]         acc_q, acc_d;
    logic [WIDTH_LOG_MAX-1:0] pos_q, pos_d, pos_inc;
    logic [2*WIDTH-1:0]       product_q, product_d;
    logic                     done_q, done_d;
    logic [WIDTH:0]           hi;
    logic [2*WIDTH-1:0]       acc_step;

    plus1 #(
        .WIDTH(WIDTH_LOG_MAX)
    ) u_pos_inc (
        .value (pos_q),
        .result(pos_inc)
    );

    // acc[2W] stays zero; the upper half plus one carry bit feeds the single adder.
    assign hi       = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, mc_q} : '0);
    assign acc_step = {hi, acc_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        mc_d      = mc_q;
        acc_d     = acc_q;
        pos_d     = pos_q;
        product_d = product_q;
        done_d    = 1'b0;
        unique case (state_q)
            STATE_IDLE: begin
                if (start) begin
                    mc_d    = multiplicand;
                    acc_d   = {{(WIDTH + 1){1'b0}}, multiplier};
                    pos_d   = '0;
                    state_d = STATE_CALC;
                end
            end
            STATE_CALC: begin
                acc_d = {1'b0, acc_step};
                pos_d = pos_inc;
                if (pos_q == WIDTH_LOG_MAX'(WIDTH - 1)) begin
                    product_d = acc_step;
                    done_d    = 1'b1;
                    state_d   = STATE_IDLE;
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= STATE_IDLE;
            mc_q      <= '0;
            acc_q     <= '0;
            pos_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mc_q      <= mc_d;
            acc_q     <= acc_d;
            pos_q     <= pos_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == STATE_CALC);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_small_multiplier.sv
// Directed bench for small_multiplier at WIDTH=8 and WIDTH=16, including abort and
// back-to-back restart behaviour.
module tb_small_multiplier;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start8 = 1'b0;
    logic [7:0]  mc8 = '0, mp8 = '0;
    logic        busy8, done8;
    logic [15:0] product8;
    logic        start16 = 1'b0;
    logic [15:0] mc16 = '0, mp16 = '0;
    logic        busy16, done16;
    logic [31:0] product16;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    small_multiplier #(.WIDTH(8), .WIDTH_LOG_MAX(5)) dut8 (
        .clock       (clock),
        .reset       (reset),
        .start       (start8),
        .multiplicand(mc8),
        .multiplier  (mp8),
        .busy        (busy8),
        .done        (done8),
        .product     (product8)
    );

    small_multiplier #(.WIDTH(16), .WIDTH_LOG_MAX(5)) dut16 (
        .clock       (clock),
        .reset       (reset),
        .start       (start16),
        .multiplicand(mc16),
        .multiplier  (mp16),
        .busy        (busy16),
        .done        (done16),
        .product     (product16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one 8-bit multiply; returns product, cycles to done and busy cycle count.
    task automatic mul8(input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] p, output int lat, output int nbusy);
        @(negedge clock);
        start8 = 1'b1;
        mc8    = a;
        mp8    = b;
        @(negedge clock);
        start8 = 1'b0;
        mc8    = 8'hA5;
        mp8    = 8'h5A;
        lat    = 1;
        nbusy  = 0;
        while (!done8 && lat < 40) begin
            if (busy8) nbusy++;
            @(negedge clock);
            lat++;
        end
        p = product8;
        if (lat >= 40) check("mul8_timeout", 64'(lat), 64'd9);
    endtask

    task automatic mul16(input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] p, output int lat);
        @(negedge clock);
        start16 = 1'b1;
        mc16    = a;
        mp16    = b;
        @(negedge clock);
        start16 = 1'b0;
        lat     = 1;
        while (!done16 && lat < 60) begin
            @(negedge clock);
            lat++;
        end
        p = product16;
        if (lat >= 60) check("mul16_timeout", 64'(lat), 64'd17);
    endtask

    initial begin
        logic [15:0] p8;
        logic [31:0] p16;
        logic [15:0] ra, rb;
        int lat, nbusy, ndone, bad_lat;

        repeat (2) @(negedge clock);
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_done", 64'(done8), 64'd0);
        check("rst_product", 64'(product8), 64'd0);
        reset = 1'b0;

        mul8(8'd13, 8'd11, p8, lat, nbusy);
        check("13x11", 64'(p8), 64'd143);
        check("13x11_latency", 64'(lat), 64'd9);
        check("13x11_busy_cycles", 64'(nbusy), 64'd8);
        check("13x11_busy_at_done", 64'(busy8), 64'd0);
        @(negedge clock);
        check("13x11_done_one_cycle", 64'(done8), 64'd0);
        check("13x11_product_held", 64'(product8), 64'd143);

        mul8(8'd255, 8'd255, p8, lat, nbusy);
        check("255x255", 64'(p8), 64'd65025);
        mul8(8'd0, 8'd200, p8, lat, nbusy);
        check("0x200", 64'(p8), 64'd0);
        check("0x200_latency", 64'(lat), 64'd9);
        mul8(8'd200, 8'd0, p8, lat, nbusy);
        check("200x0", 64'(p8), 64'd0);
        check("200x0_latency", 64'(lat), 64'd9);
        mul8(8'd128, 8'd2, p8, lat, nbusy);
        check("128x2", 64'(p8), 64'd256);

        // start held 30 edges: accepts at E0, E9, E18, E27 -> done at 8, 17, 26, 35
        @(negedge clock);
        start8 = 1'b1;
        mc8    = 8'd3;
        mp8    = 8'd4;
        ndone  = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clock);
            if (k == 29) start8 = 1'b0;
            if (done8) begin
                check("b2b_done_cycle", 64'(k), 64'(8 + 9 * ndone));
                check("b2b_product", 64'(product8), 64'd12);
                ndone++;
            end
        end
        check("b2b_done_count", 64'(ndone), 64'd4);

        // Abort 100*100 during CALC step 4
        @(negedge clock);
        start8 = 1'b1;
        mc8    = 8'd100;
        mp8    = 8'd100;
        @(negedge clock);
        start8 = 1'b0;
        repeat (3) @(negedge clock);
        check("abort_busy_before", 64'(busy8), 64'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy8), 64'd0);
        check("abort_product", 64'(product8), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clock);
            if (done8) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        mul8(8'd7, 8'd6, p8, lat, nbusy);
        check("7x6_after_abort", 64'(p8), 64'd42);

        mul16(16'hFFFF, 16'hFFFF, p16, lat);
        check("w16_ffff_sq", 64'(p16), 64'hFFFE0001);
        check("w16_latency", 64'(lat), 64'd17);
        mul16(16'd1234, 16'd5678, p16, lat);
        check("w16_1234x5678", 64'(p16), 64'd7006652);

        bad_lat = 0;
        for (int i = 0; i < 2000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            mul16(ra, rb, p16, lat);
            check("w16_random", 64'(p16), 64'(32'(ra) * 32'(rb)));
            if (lat != 17) bad_lat++;
        end
        check("w16_random_latency", 64'(bad_lat), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
